jk_ff_checker: RTL and testbench
================================

# jk_ff_checker

Synthesizable self-checking monitor for the JK master-slave flip-flop with asynchronous clear and preset. It observes the flip-flop's J, K, pre_bar, Q and Qbar alongside the flip-flop and runs a cycle-accurate golden JK model. It flags every mismatch and counts both checks and errors. It is the response-reading end of the flip-flop's stimulus interface, and it lets the lab benches and FPGA demos self-check instead of relying on eyeballing $monitor output.

## Interface
- CNT_W, 8, width of chk_cnt and err_cnt; both counters saturate at 2^CNT_W-1.
- SETTLE, 1, number of clk rising edges after a clear or preset release before comparisons start. Range 1..15.

- clk  in  1  sampling clock; the same clk that drives the flip-flop.
- clr_bar  in  1  asynchronous, active-low reset. Wire it to the flip-flop's clr_bar. The checker models the clear through this reset.
- pre_bar  in  1  the flip-flop's active-low preset, sampled on clk rising edge.
- J, K  in  1 each  the flip-flop inputs, sampled on clk rising edge.
- Q, Qbar  in  1 each  the flip-flop outputs under check.
- exp_q  out  1  golden model state.
- state  out  2  FSM state, encoded as in the package.
- err_pulse  out  1  one-cycle flag for a mismatch found at the previous edge.
- err  out  1  sticky mismatch flag.
- chk_cnt  out  CNT_W  number of comparisons performed.
- err_cnt  out  CNT_W  number of failed comparisons.

## Operation
- Reset (clr_bar=0, asynchronous):
  - exp_q=0, state=SETTLE, settle counter=0.
  - err_pulse=0, err=0, chk_cnt=0, err_cnt=0.
- Golden model, updated on every clk rising edge when out of reset:
  - pre_bar=0: exp_q<=1.
  - Otherwise, from the sampled J,K: 00 hold, 10 set, 01 reset, 11 toggle.
- Comparison contract: Q sampled at edge N+1 must equal exp_q computed at edge N.
  - A comparison fails if Q!==exp_q or Qbar!==~exp_q.
  - The comparison uses 4-state case inequality, so X or Z on Q or Qbar counts as a failure.
- FSM states: SETTLE, CHECK, PRESET.
  - SETTLE: no comparisons; the settle counter increments each edge. When the count reaches SETTLE and pre_bar=1, go to CHECK.
  - CHECK: compare every edge.
  - PRESET: entered from any state when pre_bar=0 is sampled. Each edge compares only Q===1 and Qbar===0. Leave to SETTLE (counter cleared) on the first edge that samples pre_bar=1.
  - pre_bar=0 takes priority over all other transitions.
- Counters:
  - chk_cnt increments on every comparison (CHECK and PRESET).
  - err_cnt increments on every failed comparison.
  - Both saturate and never wrap.
- Error flags:
  - err_pulse is registered: high for exactly one cycle after the failing edge.
  - err sets on the first failure and clears only on reset.
- Reset mid-operation: all outputs return to their reset values immediately, with no clock required.

## Timing
- Latency from a failing sample edge to err_pulse/err high: 1 clk rising edge (registered outputs).
- exp_q updates at the same edge on which J, K and pre_bar are sampled.
- Consecutive failures produce err_pulse high on consecutive cycles.
- First comparison after clr_bar rises: at the (SETTLE+1)-th rising edge after release.
- Simultaneous events at one edge, priority order: pre_bar=0, then settle completion, then comparison.
- A saturated counter holds its value; err_cnt stays at max and err stays 1.

## Structure
- Package jk_chk_pkg holds:
  - state encoding: SETTLE=2'd0, CHECK=2'd1, PRESET=2'd2, with 2'd3 unused and decoded to SETTLE;
  - the JK next-state function jk_next(q,j,k).
- One sub-module, sat_counter (parameter W, with inc and clear inputs), instantiated twice for chk_cnt and err_cnt.
- The FSM and the golden model live in the top module.

## Test plan
- Reset, then J=K=0 for 5 cycles with a correct flip-flop: exp_q=0, state reaches CHECK after 1 edge, chk_cnt=4, err=0.
- JK=10, 01, 11, 11, each held 2 cycles, with a correct flip-flop: exp_q sequence 1,0,toggling; err_cnt=0.
- Force Q=1 (and Qbar=0) for one cycle while expected 0: err_pulse high exactly 1 cycle, one edge later. err=1 and stays 1. err_cnt=1.
- pre_bar=0 for 2 edges, then release with JK=11: state goes PRESET, then SETTLE, then CHECK. exp_q=1 during preset, then toggles each edge; no errors with a correct flip-flop.
- CNT_W=2 with a stuck-at-0 Q over 6 toggling edges: err_cnt saturates at 3 and chk_cnt at 3; neither wraps.
- Assert clr_bar mid-CHECK between clock edges: all outputs cleared immediately. Drive Q=X after release: the first compare counts as an error.

Source files
------------

// File: rtl/jk_chk_pkg.sv
// Shared definitions for the JK flip-flop checker: FSM state encoding and the
// golden JK next-state function.
package jk_chk_pkg;

  localparam int unsigned STATE_W      = 2;
  localparam int unsigned SETTLE_CNT_W = 4;

  // Encoding 2'd3 is unused; the checker decodes it as ST_SETTLE.
  typedef enum logic [STATE_W-1:0] {
    ST_SETTLE = 2'd0,
    ST_CHECK  = 2'd1,
    ST_PRESET = 2'd2
  } chk_state_e;

  // JK next state: 00 hold, 10 set, 01 reset, 11 toggle.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nxt;
    case ({j, k})
      2'b00:   nxt = q;
      2'b10:   nxt = 1'b1;
      2'b01:   nxt = 1'b0;
      default: nxt = ~q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_ff_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one event this cycle
//   clear      : synchronous clear (wins over inc)
//   cnt        : current count, holds at all-ones
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, else increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/jk_ff_checker.sv
// Self-checking monitor for a JK flip-flop with async clear and sync-sampled
// preset. Runs a golden JK model and compares the flip-flop outputs each edge.
//   clk, clr_bar      : sampling clock, async active-low reset (the FF clear)
//   pre_bar, J, K     : flip-flop inputs, sampled on clk rising edge
//   Q, Qbar           : flip-flop outputs under check (4-state compared)
//   exp_q, state      : golden model state and checker FSM state
//   err_pulse, err    : one-cycle and sticky mismatch flags
//   chk_cnt, err_cnt  : saturating comparison / failure counters
import jk_chk_pkg::*;

module jk_ff_checker #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic               clk,
  input  logic               clr_bar,
  input  logic               pre_bar,
  input  logic               J,
  input  logic               K,
  input  logic               Q,
  input  logic               Qbar,
  output logic               exp_q,
  output logic [STATE_W-1:0] state,
  output logic               err_pulse,
  output logic               err,
  output logic [CNT_W-1:0]   chk_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_TGT = SETTLE_CNT_W'(SETTLE);

  chk_state_e              state_q, state_d;
  logic [SETTLE_CNT_W-1:0] settle_q, settle_d;
  logic                    model_q, model_d;
  logic                    err_pulse_q, err_pulse_d;
  logic                    err_q, err_d;
  logic                    cmp_en_c;
  logic                    cmp_fail_c;

  // FSM next state, golden model update and comparison.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    model_d     = pre_bar ? jk_next(model_q, J, K) : 1'b1;
    cmp_en_c    = 1'b0;
    cmp_fail_c  = 1'b0;

    case (state_q)
      ST_CHECK: begin
        // A preset edge suppresses the normal comparison: Q is moving to 1.
        if (!pre_bar) begin
          state_d = ST_PRESET;
        end else begin
          cmp_en_c   = 1'b1;
          cmp_fail_c = (Q !== model_q) || (Qbar !== ~model_q);
        end
      end
      ST_PRESET: begin
        cmp_en_c   = 1'b1;
        cmp_fail_c = (Q !== 1'b1) || (Qbar !== 1'b0);
        if (pre_bar) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      default: begin
        if (!pre_bar) begin
          state_d = ST_PRESET;
        end else begin
          settle_d = settle_q + SETTLE_CNT_W'(1);
          if (settle_d >= SETTLE_TGT) begin
            state_d = ST_CHECK;
          end
        end
      end
    endcase

    err_pulse_d = cmp_en_c && cmp_fail_c;
    err_d       = err_q || err_pulse_d;
  end

  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      state_q     <= ST_SETTLE;
      settle_q    <= '0;
      model_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      model_q     <= model_d;
      err_pulse_q <= err_pulse_d;
      err_q       <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_chk_cnt (
    .clk   (clk),
    .rst_n (clr_bar),
    .inc   (cmp_en_c),
    .clear (1'b0),
    .cnt   (chk_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (clr_bar),
    .inc   (err_pulse_d),
    .clear (1'b0),
    .cnt   (err_cnt)
  );

  assign exp_q     = model_q;
  assign state     = state_q;
  assign err_pulse = err_pulse_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jk_ff_checker.sv
// Bench for jk_ff_checker: a correct/faulty flip-flop stand-in drives dut,
// a stuck-at-0 flip-flop drives dut_sat (2-bit counters).
module tb_jk_ff_checker;

  localparam int unsigned SETTLE = 1;

  logic       clk = 1'b0;
  logic       clr_bar;
  logic       pre_bar;
  logic       J, K;
  logic       q_in, qbar_in;
  logic       q_stuck, qbar_stuck;

  logic       exp_q, err_pulse, err;
  logic [1:0] state;
  logic [7:0] chk_cnt, err_cnt;

  logic       s_exp_q, s_err_pulse, s_err;
  logic [1:0] s_state;
  logic [1:0] s_chk_cnt, s_err_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural reference model.
  logic m_exp = 1'b0;
  int   m_since = 0;
  bit   m_preset = 1'b0;
  bit   m_cmp;
  logic m_want;
  bit   m_fail [2];
  bit   m_pulse [2];
  bit   m_sticky [2];
  int   m_chk [2];
  int   m_errc [2];
  int   m_max [2] = '{255, 3};

  jk_ff_checker #(.CNT_W(8), .SETTLE(SETTLE)) dut (
    .clk(clk), .clr_bar(clr_bar), .pre_bar(pre_bar), .J(J), .K(K),
    .Q(q_in), .Qbar(qbar_in), .exp_q(exp_q), .state(state),
    .err_pulse(err_pulse), .err(err), .chk_cnt(chk_cnt), .err_cnt(err_cnt)
  );

  jk_ff_checker #(.CNT_W(2), .SETTLE(SETTLE)) dut_sat (
    .clk(clk), .clr_bar(clr_bar), .pre_bar(pre_bar), .J(J), .K(K),
    .Q(q_stuck), .Qbar(qbar_stuck), .exp_q(s_exp_q), .state(s_state),
    .err_pulse(s_err_pulse), .err(s_err), .chk_cnt(s_chk_cnt), .err_cnt(s_err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      m_exp = 1'b0;
      m_since = 0;
      m_preset = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_pulse[i] = 1'b0; m_sticky[i] = 1'b0; m_chk[i] = 0; m_errc[i] = 0;
      end
    end else begin
      m_cmp = 1'b0;
      m_want = m_exp;
      if (m_preset) begin
        m_cmp = 1'b1;
        m_want = 1'b1;
      end else if (pre_bar && m_since >= SETTLE) begin
        m_cmp = 1'b1;
      end
      m_fail[0] = m_cmp && !((q_in === m_want) && (qbar_in === ~m_want));
      m_fail[1] = m_cmp && !((q_stuck === m_want) && (qbar_stuck === ~m_want));
      for (int i = 0; i < 2; i++) begin
        m_pulse[i] = m_fail[i];
        if (m_fail[i]) m_sticky[i] = 1'b1;
        if (m_cmp && m_chk[i] < m_max[i]) m_chk[i] = m_chk[i] + 1;
        if (m_fail[i] && m_errc[i] < m_max[i]) m_errc[i] = m_errc[i] + 1;
      end
      if (!pre_bar) m_preset = 1'b1;
      else if (m_preset) begin m_preset = 1'b0; m_since = 0; end
      else if (m_since < SETTLE) m_since = m_since + 1;
      if (!pre_bar) m_exp = 1'b1;
      else if (J && K) m_exp = ~m_exp;
      else if (J) m_exp = 1'b1;
      else if (K) m_exp = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    int st;
    st = m_preset ? 2 : ((m_since >= SETTLE) ? 1 : 0);
    chk({tag, ".exp_q"},     32'(exp_q),       32'(m_exp));
    chk({tag, ".state"},     32'(state),       32'(st));
    chk({tag, ".err_pulse"}, 32'(err_pulse),   32'(m_pulse[0]));
    chk({tag, ".err"},       32'(err),         32'(m_sticky[0]));
    chk({tag, ".chk_cnt"},   32'(chk_cnt),     32'(m_chk[0]));
    chk({tag, ".err_cnt"},   32'(err_cnt),     32'(m_errc[0]));
    chk({tag, ".s_exp_q"},   32'(s_exp_q),     32'(m_exp));
    chk({tag, ".s_state"},   32'(s_state),     32'(st));
    chk({tag, ".s_pulse"},   32'(s_err_pulse), 32'(m_pulse[1]));
    chk({tag, ".s_err"},     32'(s_err),       32'(m_sticky[1]));
    chk({tag, ".s_chk_cnt"}, 32'(s_chk_cnt),   32'(m_chk[1]));
    chk({tag, ".s_err_cnt"}, 32'(s_err_cnt),   32'(m_errc[1]));
  endtask

  // Drive one cycle from a negedge; fault 0 = correct FF, 1 = inverted, 2 = X.
  task automatic step(input logic j, input logic k, input logic p, input int fault, input string tag);
    J = j; K = k; pre_bar = p;
    if (fault == 1) begin
      q_in = ~m_exp; qbar_in = m_exp;
    end else if (fault == 2) begin
      q_in = 1'bx; qbar_in = 1'bx;
    end else begin
      q_in = m_exp; qbar_in = ~m_exp;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    clr_bar = 1'b1; pre_bar = 1'b1; J = 1'b0; K = 1'b0;
    q_in = 1'b0; qbar_in = 1'b1; q_stuck = 1'b0; qbar_stuck = 1'b1;
    #1 clr_bar = 1'b0;
    @(negedge clk);
    check_all("reset");
    chk("reset.state_const", 32'(state), 32'd0);
    clr_bar = 1'b1;

    // Hold with a correct flip-flop.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 0, "hold");
    chk("hold.chk_cnt4", 32'(chk_cnt), 32'd4);
    chk("hold.state_check", 32'(state), 32'd1);

    // Set, reset, toggle.
    step(1'b1, 1'b0, 1'b1, 0, "set");  step(1'b1, 1'b0, 1'b1, 0, "set");
    step(1'b0, 1'b1, 1'b1, 0, "rst");  step(1'b0, 1'b1, 1'b1, 0, "rst");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 0, "tog");
    chk("jk.err_cnt0", 32'(err_cnt), 32'd0);
    chk("sat.chk_cnt3", 32'(s_chk_cnt), 32'd3);
    chk("sat.err_cnt3", 32'(s_err_cnt), 32'd3);

    // Single injected mismatch.
    step(1'b0, 1'b1, 1'b1, 0, "pre_inj");
    step(1'b0, 1'b0, 1'b1, 1, "inj");
    chk("inj.pulse_hi", 32'(err_pulse), 32'd1);
    step(1'b0, 1'b0, 1'b1, 0, "post_inj");
    chk("inj.pulse_lo", 32'(err_pulse), 32'd0);
    chk("inj.err_sticky", 32'(err), 32'd1);
    chk("inj.err_cnt1", 32'(err_cnt), 32'd1);

    // Preset for two edges, then release with toggling.
    step(1'b1, 1'b1, 1'b0, 0, "preset");
    chk("preset.state", 32'(state), 32'd2);
    step(1'b1, 1'b1, 1'b0, 0, "preset");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 0, "rel");
    chk("rel.err_cnt1", 32'(err_cnt), 32'd1);

    // Randomized traffic with occasional presets and faults.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1,
           ($urandom_range(0, 15) == 0) ? 1 : 0, "rand");
    end

    // Settle back into CHECK, then clear between edges.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 0, "pre_clr");
    #2 clr_bar = 1'b0;
    #1;
    check_all("async_clr");
    chk("async_clr.err", 32'(err), 32'd0);
    chk("async_clr.chk_cnt", 32'(chk_cnt), 32'd0);
    chk("async_clr.s_err_cnt", 32'(s_err_cnt), 32'd0);
    @(negedge clk);
    clr_bar = 1'b1;

    // X on the flip-flop outputs at the first comparison.
    step(1'b0, 1'b0, 1'b1, 0, "x_settle");
    step(1'b0, 1'b0, 1'b1, 2, "x_cmp");
    chk("x.pulse", 32'(err_pulse), 32'd1);
    step(1'b0, 1'b0, 1'b1, 0, "x_after");
    chk("x.err_cnt1", 32'(err_cnt), 32'd1);
    chk("x.chk_cnt2", 32'(chk_cnt), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
